// File: rtl/onchip_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port on-chip RAM.
// Commands are granted combinationally; read responses are routed back through a tag pipeline.
module onchip_mem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic [1:0]            rst_sync_q;
  logic                  reset_n_sync_state;
  logic                  req0, req1;
  logic                  active0, active1;
  logic                  grant0, grant1;
  logic                  any_grant;
  logic                  rd_accept;
  logic                  last_grant;
  logic [RD_LATENCY-1:0] tag_valid;
  logic [RD_LATENCY-1:0] tag_id;

  // Reset asserts immediately but releases two clocks later, in step with clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign reset_n_sync_state = rst_sync_q[1];

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign active0 = req0 & reset_n_sync_state;
  assign active1 = req1 & reset_n_sync_state;

  // Under contention the requester that did not win last time gets the memory.
  assign grant0    = active0 & (~active1 | last_grant);
  assign grant1    = active1 & (~active0 | ~last_grant);
  assign any_grant = grant0 | grant1;

  assign m0_waitrequest = ~reset_n_sync_state | (req0 & ~grant0);
  assign m1_waitrequest = ~reset_n_sync_state | (req1 & ~grant1);

  // A read with write also asserted is a write and never gets a response.
  assign rd_accept = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    if (grant0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
    end else if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
  end

  assign mem_chipselect = any_grant;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (any_grant) begin
      last_grant <= grant1;
    end
  end

  // Each stage carries {valid, requester id} for a read in flight through the RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid[0] <= rd_accept;
      tag_id[0]    <= grant1;
      for (int k = 1; k < RD_LATENCY; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  assign m0_readdatavalid = tag_valid[RD_LATENCY-1] & ~tag_id[RD_LATENCY-1];
  assign m1_readdatavalid = tag_valid[RD_LATENCY-1] &  tag_id[RD_LATENCY-1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural registered-output RAM
// and a scoreboard that matches read responses against expected data and arrival cycle.
module tb_onchip_mem_arbiter;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [5:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_wait;
    logic        exp_resp;
    logic [31:0] exp_data;
  } cmd_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [5:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [5:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  logic [31:0] ram [64];
  logic [5:0]  ram_addr_q;
  logic [31:0] ram_data_q;

  int   cyc = 0;
  int   asserts = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;
  cmd_t idle;

  onchip_mem_arbiter #(.ADDR_W(6), .DATA_W(32), .RD_LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM: address registered at the edge, output register one edge later.
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
    ram_addr_q <= mem_address;
    ram_data_q <= ram[ram_addr_q];
  end
  assign mem_readdata = ram_data_q;

  function automatic cmd_t mk(input logic rd, input logic wr, input logic [5:0] a,
                              input logic [3:0] be, input logic [31:0] wd,
                              input logic ew, input logic er, input logic [31:0] ed);
    cmd_t c;
    c.read = rd; c.write = wr; c.addr = a; c.be = be; c.wdata = wd;
    c.exp_wait = ew; c.exp_resp = er; c.exp_data = ed;
    return c;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input cmd_t c0, input cmd_t c1);
    m0_read = c0.read; m0_write = c0.write; m0_address = c0.addr;
    m0_byteenable = c0.be; m0_writedata = c0.wdata;
    m1_read = c1.read; m1_write = c1.write; m1_address = c1.addr;
    m1_byteenable = c1.be; m1_writedata = c1.wdata;
  endtask

  // One cycle of stimulus; accepted reads push their expected response two cycles ahead.
  task automatic apply_stimulus(input cmd_t c0, input cmd_t c1);
    exp_t e;
    drive(c0, c1);
    @(negedge clk);
    check_output("m0_waitrequest", {31'd0, m0_waitrequest}, {31'd0, c0.exp_wait});
    check_output("m1_waitrequest", {31'd0, m1_waitrequest}, {31'd0, c1.exp_wait});
    if (c0.exp_resp) begin e.data = c0.exp_data; e.due = cyc + 2; q0.push_back(e); end
    if (c1.exp_resp) begin e.data = c1.exp_data; e.due = cyc + 2; q1.push_back(e); end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response must match the oldest expectation, in data and in cycle.
  always @(negedge clk) begin
    if (q0.size() > 0 && q0[0].due < cyc) begin
      asserts++; fails++;
      $display("[TB] FAIL m0_missing_rdv: got no pulse, expected data 0x%08h in cycle %0d", q0[0].data, q0[0].due);
      void'(q0.pop_front());
    end
    if (q1.size() > 0 && q1[0].due < cyc) begin
      asserts++; fails++;
      $display("[TB] FAIL m1_missing_rdv: got no pulse, expected data 0x%08h in cycle %0d", q1[0].data, q1[0].due);
      void'(q1.pop_front());
    end
    if (m0_readdatavalid === 1'b1) begin
      if (q0.size() == 0) begin
        asserts++; fails++;
        $display("[TB] FAIL m0_extra_rdv: got pulse with 0x%08h, expected none (cycle %0d)", m0_readdata, cyc);
      end else begin
        mon_e = q0.pop_front();
        check_output("m0_readdata", m0_readdata, mon_e.data);
        check_output("m0_rdv_cycle", cyc, mon_e.due);
      end
    end
    if (m1_readdatavalid === 1'b1) begin
      if (q1.size() == 0) begin
        asserts++; fails++;
        $display("[TB] FAIL m1_extra_rdv: got pulse with 0x%08h, expected none (cycle %0d)", m1_readdata, cyc);
      end else begin
        mon_e = q1.pop_front();
        check_output("m1_readdata", m1_readdata, mon_e.data);
        check_output("m1_rdv_cycle", cyc, mon_e.due);
      end
    end
  end

  initial begin
    idle = mk(0, 0, 6'd0, 4'h0, 32'h0, 0, 0, 32'h0);
    reset_n = 1'b0;
    drive(idle, idle);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_output("rst_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    check_output("rst_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    check_output("rst_chipselect", {31'd0, mem_chipselect}, 32'd0);
    check_output("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check_output("rst_clken", {31'd0, mem_clken}, 32'd1);
    check_output("rst_m0_rdv", {31'd0, m0_readdatavalid}, 32'd0);
    check_output("rst_m1_rdv", {31'd0, m1_readdatavalid}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] basic write/read on m0");
    apply_stimulus(mk(0, 1, 6'd5, 4'hF, 32'hDEADBEEF, 0, 0, 0), idle);
    apply_stimulus(mk(1, 0, 6'd5, 4'h0, 32'h0, 0, 1, 32'hDEADBEEF), idle);
    repeat (3) apply_stimulus(idle, idle);

    $display("[TB] byte lanes");
    apply_stimulus(mk(0, 1, 6'd0, 4'hF, 32'h11223344, 0, 0, 0), idle);
    apply_stimulus(mk(0, 1, 6'd0, 4'h5, 32'hAABBCCDD, 0, 0, 0), idle);
    apply_stimulus(mk(1, 0, 6'd0, 4'h0, 32'h0, 0, 1, 32'h11BB33DD), idle);
    repeat (3) apply_stimulus(idle, idle);

    $display("[TB] contention");
    apply_stimulus(mk(0, 1, 6'd1, 4'hF, 32'h1, 0, 0, 0), idle);
    apply_stimulus(idle, mk(0, 1, 6'd2, 4'hF, 32'h2, 0, 0, 0));
    apply_stimulus(mk(1, 0, 6'd1, 4'h0, 0, 0, 1, 32'h1), mk(1, 0, 6'd2, 4'h0, 0, 1, 0, 0));
    apply_stimulus(mk(1, 0, 6'd1, 4'h0, 0, 1, 0, 0),     mk(1, 0, 6'd2, 4'h0, 0, 0, 1, 32'h2));
    apply_stimulus(mk(1, 0, 6'd1, 4'h0, 0, 0, 1, 32'h1), mk(1, 0, 6'd2, 4'h0, 0, 1, 0, 0));
    apply_stimulus(mk(1, 0, 6'd1, 4'h0, 0, 1, 0, 0),     mk(1, 0, 6'd2, 4'h0, 0, 0, 1, 32'h2));
    repeat (3) apply_stimulus(idle, idle);

    $display("[TB] mixed traffic on addr 63");
    apply_stimulus(mk(0, 1, 6'd63, 4'hF, 32'h55, 0, 0, 0), mk(1, 0, 6'd63, 4'h0, 0, 1, 0, 0));
    apply_stimulus(idle, mk(1, 0, 6'd63, 4'h0, 0, 0, 1, 32'h55));
    repeat (3) apply_stimulus(idle, idle);

    $display("[TB] reset with reads in flight");
    apply_stimulus(idle, mk(1, 0, 6'd2, 4'h0, 0, 0, 0, 0));
    apply_stimulus(idle, mk(1, 0, 6'd1, 4'h0, 0, 0, 0, 0));
    reset_n = 1'b0;
    drive(idle, idle);
    @(negedge clk);
    check_output("midrst_m1_rdv", {31'd0, m1_readdatavalid}, 32'd0);
    check_output("midrst_chipselect", {31'd0, mem_chipselect}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    apply_stimulus(mk(1, 0, 6'd1, 4'h0, 0, 0, 1, 32'h1), mk(1, 0, 6'd2, 4'h0, 0, 1, 0, 0));
    apply_stimulus(idle, mk(1, 0, 6'd2, 4'h0, 0, 0, 1, 32'h2));
    repeat (3) apply_stimulus(idle, idle);

    $display("[TB] read+write together on m1");
    apply_stimulus(idle, mk(1, 1, 6'd10, 4'hF, 32'hCAFEF00D, 0, 0, 0));
    apply_stimulus(mk(1, 0, 6'd10, 4'h0, 0, 0, 1, 32'hCAFEF00D), idle);
    repeat (4) apply_stimulus(idle, idle);

    check_output("drain_q0", 32'(q0.size()), 32'd0);
    check_output("drain_q1", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-requester Avalon-MM arbiter that shares the single-port 64x32 on-chip memory (altsyncram-based, byte-enabled, registered read output) between two masters. It issues at most one command per cycle to the memory, grants round-robin under contention, and returns tagged read data with fixed 2-cycle latency on the owning requester's `readdatavalid`. It sits between the interconnect masters and the memory's `s1` port, with the memory's `clken` held high and `reset_req` held low.

## Interface
- `ADDR_W`, 6: word-address width (64 words).
- `DATA_W`, 32: data width; byteenable width is `DATA_W/8`.
- `RD_LATENCY`, 2: memory read latency in cycles; fixed for this memory, parameterised only for the pipeline depth.

- `clk`  in  1  single clock for the arbiter and the memory.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mN_address`  in  ADDR_W  requester N word address (N = 0, 1).
- `mN_byteenable`  in  DATA_W/8  requester N byte lanes (write only).
- `mN_read`, `mN_write`  in  1 each  requester N command strobes.
- `mN_writedata`  in  DATA_W  requester N write data.
- `mN_waitrequest`  out  1  command not accepted this cycle.
- `mN_readdata`  out  DATA_W  read data, valid with `mN_readdatavalid`.
- `mN_readdatavalid`  out  1  one-cycle pulse per accepted read.
- `mem_address`  out  ADDR_W  to memory `address`.
- `mem_byteenable`  out  DATA_W/8  to memory `byteenable`.
- `mem_chipselect`  out  1  to memory `chipselect`.
- `mem_write`  out  1  to memory `write`.
- `mem_writedata`  out  DATA_W  to memory `writedata`.
- `mem_clken`  out  1  to memory `clken`; constant 1.
- `mem_readdata`  in  DATA_W  from memory `readdata`.

## Operation
- Request: `mN_req = mN_read | mN_write`. Read and write asserted together are treated as a write. No `readdatavalid` is produced for such a command.
- Grant (combinational, same cycle):
  - Only one requester active: that requester is granted.
  - Both active: the requester not named by `last_grant` is granted.
  - `last_grant` register: reset value 1 (so m0 wins the first conflict). It updates to the granted index on every cycle with a grant.
- `mN_waitrequest = ~reset_n_sync_state | (mN_req & ~grantN)`.
  - During reset and while no request is pending, `waitrequest` is 1 for idle ports. This is allowed per Avalon.
  - A requester is accepted in the cycle where `mN_req=1` and `mN_waitrequest=0`.
- Memory drive:
  - Muxed from the granted requester: address, byteenable, writedata, `mem_write = granted write`, `mem_chipselect = any grant`.
  - No grant: all muxed outputs 0.
- Read-tag pipeline:
  - `RD_LATENCY`-deep shift register of `{valid, id}`.
  - Stage 0 loads `{accepted read, granted index}` each cycle; stage k loads stage k-1.
  - At the last stage: if valid, drive `m<id>_readdatavalid=1`.
  - `mN_readdata` is driven from `mem_readdata` unconditionally to both ports; only `readdatavalid` qualifies it.
- Writes complete on acceptance; no response.
- Back-to-back commands every cycle are supported; the arbiter introduces no bubbles.

## Timing
- Reset (async assert, sync deassert on `clk`): pipeline valids 0, `last_grant=1`, all `readdatavalid=0`, `mem_chipselect=0`, `mem_write=0`, `mem_clken=1`. Reset does not wait for in-flight reads.
- Read accepted in cycle C → `mN_readdatavalid=1` in cycle C+2 with the data of that address.
  - Edge ending C: RAM registers the address.
  - Edge ending C+1: the memory output register captures the data.
- Write accepted in cycle C, then a read of the same address accepted in C+1 → the read returns the new data (single-port, write lands at the edge ending C).
- Reset asserted with reads in flight: the pipeline is cleared immediately and no `readdatavalid` is emitted for those reads after reset releases.
- Both requesters reading continuously: grants alternate m0, m1, m0, …. `readdatavalid` alternates likewise 2 cycles later, with one pulse per cycle total.
- `waitrequest` and the `mem_*` command outputs are combinational from requests and `last_grant`. `readdatavalid` is registered.

## Test plan
- Reset, then m0 writes 0xDEADBEEF to addr 5 (be=0xF), then m0 reads addr 5 → `m0_waitrequest=0` on both commands; `m0_readdatavalid` exactly 2 cycles after the read, `m0_readdata=0xDEADBEEF`; `m1_readdatavalid` stays 0.
- Byte lanes: write 0x11223344 to addr 0, then write 0xAABBCCDD with be=0x5, then read addr 0 → read returns 0x11BB33DD.
- Contention: m0 and m1 both hold reads to addr 1 and addr 2 (preloaded 0x1, 0x2) for 4 cycles.
  - Grants go m0, m1, m0, m1.
  - Each port has `waitrequest=1` on alternate cycles.
  - `readdatavalid` pulses interleave 2 cycles later with 0x1/0x2 routed correctly.
- Mixed traffic: m0 writes 0x55 to addr 63 in cycle C while m1 requests a read of addr 63.
  - m0 wins the first conflict, so the m1 read is accepted in C+1.
  - `m1_readdata=0x55` in C+3.
- Reset mid-operation: accept two m1 reads, assert `reset_n=0` one cycle later for 1 cycle → no `readdatavalid` pulses afterwards. The next conflict after release is granted to m0.
- Illegal read+write asserted together on m1: treated as a write (memory updated) and no `m1_readdatavalid` is produced.
